shared_queueing_domain: RTL and testbench

//  Next-generation queueing domain. NUM_QUEUES per-core queues share a single BUFFER_DEPTH-entry packet RAM.
//  Per-queue order is kept as linked lists over one next-pointer array; unused slots form a linked free list.

---
 rtl/shq_pkg.sv | 16 +
 rtl/shared_queueing_domain_if.sv | 30 +++
 rtl/shq_free_list.sv | 66 ++++++
 rtl/shared_queueing_domain.sv | 202 ++++++++++++++++++++
 tb/tb_shared_queueing_domain.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/shq_pkg.sv
// Shared queueing domain package: counter-width helper and the popped-packet record.
// Optional peak tracking elsewhere is enabled by defining SHQ_WATERMARK_EN.
package shq_pkg;

    localparam int unsigned SHQ_DATA_SIZE = 678;

    typedef struct packed {
        logic                     valid;
        logic [SHQ_DATA_SIZE-1:0] data;
    } shq_pop_t;

    function automatic int unsigned count_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/shared_queueing_domain_if.sv
// Push (dispatcher) and pop (scheduler) handshakes of the shared queueing domain.
// master = dispatcher/scheduler side, slave = the queueing domain.
interface shared_queueing_domain_if #(
    parameter int unsigned NUM_QUEUES = 4,
    parameter int unsigned DATA_SIZE  = 678
);
    localparam int unsigned QW = $clog2(NUM_QUEUES);

    logic                 push_valid;
    logic [QW-1:0]        push_queue;
    logic [DATA_SIZE-1:0] push_data;
    logic                 push_ready;

    logic                 pop_valid;
    logic [QW-1:0]        pop_queue;
    logic                 pop_ready;
    logic [DATA_SIZE-1:0] pop_data;
    logic                 pop_data_valid;

    modport master (
        output push_valid, push_queue, push_data, pop_valid, pop_queue,
        input  push_ready, pop_ready, pop_data, pop_data_valid
    );

    modport slave (
        input  push_valid, push_queue, push_data, pop_valid, pop_queue,
        output push_ready, pop_ready, pop_data, pop_data_valid
    );

endinterface

// File: rtl/shq_free_list.sv
// Linked free list of packet slots: owns head, tail and count; links live in the
// shared next-pointer array, reached through head_next and the nxt_* write port.
module shq_free_list
    import shq_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      alloc,
    input  logic                      rel_valid,
    input  logic [$clog2(DEPTH)-1:0]  rel_slot,
    input  logic [$clog2(DEPTH)-1:0]  head_next,
    output logic [$clog2(DEPTH)-1:0]  free_head,
    output logic [count_w(DEPTH)-1:0] free_count,
    output logic                      nxt_we,
    output logic [$clog2(DEPTH)-1:0]  nxt_waddr,
    output logic [$clog2(DEPTH)-1:0]  nxt_wdata
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = count_w(DEPTH);

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    ptr_t head_q, head_d;
    ptr_t tail_q, tail_d;
    cnt_t count_q, count_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= ptr_t'(DEPTH - 1);
            count_q <= cnt_t'(DEPTH);
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q + cnt_t'(rel_valid) - cnt_t'(alloc);
        nxt_we    = 1'b0;
        nxt_waddr = tail_q;
        nxt_wdata = rel_slot;
        if (alloc) begin
            head_d = head_next;
        end
        if (rel_valid) begin
            // List drains this cycle (empty, or last slot allocated): returned slot becomes head and tail.
            if (count_q == cnt_t'(alloc)) begin
                head_d = rel_slot;
            end else begin
                nxt_we = 1'b1;
            end
            tail_d = rel_slot;
        end
    end

    assign free_head  = head_q;
    assign free_count = count_q;

endmodule

// File: rtl/shared_queueing_domain.sv
// NUM_QUEUES linked-list queues sharing one BUFFER_DEPTH-slot packet RAM, with occupancy and kill flags.
// Define SHQ_WATERMARK_EN to add per-queue peak occupancy tracking (peak_occupancy, watermark_clear).
module shared_queueing_domain
    import shq_pkg::*;
#(
    parameter int unsigned NUM_QUEUES    = 4,
    parameter int unsigned DATA_SIZE     = 678,
    parameter int unsigned BUFFER_DEPTH  = 16,
    parameter int unsigned REGISTER_SIZE = 32
) (
    input  logic                                        clock,
    input  logic                                        reset,
    input  logic [NUM_QUEUES*REGISTER_SIZE-1:0]         higher_threshold,
    shared_queueing_domain_if.slave                     bus,
    output logic [NUM_QUEUES-1:0]                       empty,
    output logic [NUM_QUEUES-1:0]                       last_elem,
    output logic [NUM_QUEUES*count_w(BUFFER_DEPTH)-1:0] occupancy,
    output logic [count_w(BUFFER_DEPTH)-1:0]            free_count,
    output logic [NUM_QUEUES-1:0]                       kill_the_core
`ifdef SHQ_WATERMARK_EN
    ,
    input  logic                                        watermark_clear,
    output logic [NUM_QUEUES*count_w(BUFFER_DEPTH)-1:0] peak_occupancy
`endif
);
    localparam int unsigned PTR_W = $clog2(BUFFER_DEPTH);
    localparam int unsigned CNT_W = count_w(BUFFER_DEPTH);
    localparam int unsigned QW    = $clog2(NUM_QUEUES);

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    ptr_t nxt_q  [BUFFER_DEPTH];
    ptr_t nxt_d  [BUFFER_DEPTH];
    ptr_t head_q [NUM_QUEUES];
    ptr_t head_d [NUM_QUEUES];
    ptr_t tail_q [NUM_QUEUES];
    ptr_t tail_d [NUM_QUEUES];
    cnt_t occ_q  [NUM_QUEUES];
    cnt_t occ_d  [NUM_QUEUES];

    logic [NUM_QUEUES-1:0] kill_q, kill_d;
    logic                  pop_valid_q, pop_valid_d;
    logic [DATA_SIZE-1:0]  pop_data_q;
    logic [DATA_SIZE-1:0]  ram [BUFFER_DEPTH];

    logic                  push_acc, pop_acc;
    logic [NUM_QUEUES-1:0] push_hit, pop_hit;
    ptr_t                  pop_slot, free_head;
    cnt_t                  free_cnt;
    logic                  q_we, fl_we;
    ptr_t                  fl_waddr, fl_wdata;
    shq_pop_t              pop_out;

    shq_free_list #(
        .DEPTH (BUFFER_DEPTH)
    ) u_free_list (
        .clock      (clock),
        .reset      (reset),
        .alloc      (push_acc),
        .rel_valid  (pop_acc),
        .rel_slot   (pop_slot),
        .head_next  (nxt_q[free_head]),
        .free_head  (free_head),
        .free_count (free_cnt),
        .nxt_we     (fl_we),
        .nxt_waddr  (fl_waddr),
        .nxt_wdata  (fl_wdata)
    );

    always_comb begin
        for (int unsigned q = 0; q < NUM_QUEUES; q++) begin
            empty[q]     = (occ_q[q] == '0);
            last_elem[q] = (occ_q[q] == cnt_t'(1));
            occupancy[q*CNT_W +: CNT_W] = occ_q[q];
        end
    end

    assign free_count     = free_cnt;
    assign kill_the_core  = kill_q;
    assign bus.push_ready = (free_cnt != '0);
    assign bus.pop_ready  = !empty[bus.pop_queue];
    assign push_acc       = bus.push_valid && bus.push_ready;
    assign pop_acc        = bus.pop_valid && bus.pop_ready;
    assign pop_slot       = head_q[bus.pop_queue];

    always_comb begin
        for (int unsigned q = 0; q < NUM_QUEUES; q++) begin
            push_hit[q] = push_acc && (bus.push_queue == QW'(q));
            pop_hit[q]  = pop_acc && (bus.pop_queue == QW'(q));
        end
    end

    // Link the old tail only when the queue still holds something after this cycle's pop.
    assign q_we = push_acc && (occ_q[bus.push_queue] != cnt_t'(pop_hit[bus.push_queue]));

    always_comb begin
        for (int unsigned q = 0; q < NUM_QUEUES; q++) begin
            head_d[q] = head_q[q];
            tail_d[q] = tail_q[q];
            occ_d[q]  = occ_q[q] + cnt_t'(push_hit[q]) - cnt_t'(pop_hit[q]);
            if (pop_hit[q]) begin
                head_d[q] = nxt_q[head_q[q]];
            end
            if (push_hit[q]) begin
                tail_d[q] = free_head;
                if (occ_q[q] == cnt_t'(pop_hit[q])) begin
                    head_d[q] = free_head;
                end
            end
        end
    end

    // Queue-tail and free-tail writes always hit distinct slots (allocated vs free).
    always_comb begin
        nxt_d = nxt_q;
        if (q_we) begin
            nxt_d[tail_q[bus.push_queue]] = free_head;
        end
        if (fl_we) begin
            nxt_d[fl_waddr] = fl_wdata;
        end
    end

    always_comb begin
        for (int unsigned q = 0; q < NUM_QUEUES; q++) begin
            kill_d[q] = (higher_threshold[q*REGISTER_SIZE +: REGISTER_SIZE] != '0) &&
                        (REGISTER_SIZE'(occ_d[q]) > higher_threshold[q*REGISTER_SIZE +: REGISTER_SIZE]);
        end
    end

    assign pop_valid_d = pop_acc;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < BUFFER_DEPTH; i++) begin
                nxt_q[i] <= ptr_t'(i + 1);
            end
            for (int unsigned q = 0; q < NUM_QUEUES; q++) begin
                head_q[q] <= '0;
                tail_q[q] <= '0;
                occ_q[q]  <= '0;
            end
            kill_q      <= '0;
            pop_valid_q <= 1'b0;
        end else begin
            nxt_q       <= nxt_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            occ_q       <= occ_d;
            kill_q      <= kill_d;
            pop_valid_q <= pop_valid_d;
        end
    end

    // Packet RAM: simple dual-port, synchronous read, deliberately not reset.
    always_ff @(posedge clock) begin
        if (push_acc) begin
            ram[free_head] <= bus.push_data;
        end
        if (pop_acc) begin
            pop_data_q <= ram[pop_slot];
        end
    end

    always_comb begin
        pop_out.valid = pop_valid_q;
        pop_out.data  = SHQ_DATA_SIZE'(pop_data_q);
    end

    assign bus.pop_data_valid = pop_out.valid;
    assign bus.pop_data       = DATA_SIZE'(pop_out.data);

`ifdef SHQ_WATERMARK_EN
    cnt_t peak_q [NUM_QUEUES];
    cnt_t peak_d [NUM_QUEUES];

    always_comb begin
        for (int unsigned q = 0; q < NUM_QUEUES; q++) begin
            if (watermark_clear) begin
                peak_d[q] = occ_q[q];
            end else if (occ_d[q] > peak_q[q]) begin
                peak_d[q] = occ_d[q];
            end else begin
                peak_d[q] = peak_q[q];
            end
            peak_occupancy[q*CNT_W +: CNT_W] = peak_q[q];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned q = 0; q < NUM_QUEUES; q++) begin
                peak_q[q] <= '0;
            end
        end else begin
            peak_q <= peak_d;
        end
    end
`endif

endmodule

// File: tb/tb_shared_queueing_domain.sv
// Scoreboard bench for shared_queueing_domain: directed scenarios plus a short random run
// with per-cycle occupancy/free-count invariant checks.
module tb_shared_queueing_domain;
    import shq_pkg::*;

    localparam int NQ    = 4;
    localparam int DW    = 678;
    localparam int DEPTH = 16;
    localparam int RS    = 32;
    localparam int CW    = 5;

    typedef logic [DW-1:0] data_t;
    typedef struct {
        data_t data;
        int    due;
    } exp_t;

    logic              clock = 1'b0;
    logic              reset;
    logic [NQ*RS-1:0]  thr;
    logic [NQ-1:0]     empty, last_elem, kill;
    logic [NQ*CW-1:0]  occupancy;
    logic [CW-1:0]     free_count;
`ifdef SHQ_WATERMARK_EN
    logic              watermark_clear;
    logic [NQ*CW-1:0]  peak_occupancy;
`endif

    shared_queueing_domain_if #(.NUM_QUEUES(NQ), .DATA_SIZE(DW)) bus ();

    shared_queueing_domain #(
        .NUM_QUEUES    (NQ),
        .DATA_SIZE     (DW),
        .BUFFER_DEPTH  (DEPTH),
        .REGISTER_SIZE (RS)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .higher_threshold (thr),
        .bus              (bus),
        .empty            (empty),
        .last_elem        (last_elem),
        .occupancy        (occupancy),
        .free_count       (free_count),
        .kill_the_core    (kill)
`ifdef SHQ_WATERMARK_EN
        ,
        .watermark_clear  (watermark_clear),
        .peak_occupancy   (peak_occupancy)
`endif
    );

    always #5 clock = ~clock;

    int    n_vec = 0;
    int    n_err = 0;
    int    cyc   = 0;
    exp_t  exp_q[$];
    data_t mq[NQ][$];

    function automatic int occ_of(input int q);
        return int'(occupancy[q*CW +: CW]);
    endfunction

    task automatic check(input string nm, input longint unsigned act, input longint unsigned exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int model_total();
        int t = 0;
        for (int i = 0; i < NQ; i++) t += mq[i].size();
        return t;
    endfunction

    // One clock of stimulus; entered and left at posedge+1.
    task automatic cycle(input bit pv, input int pq, input data_t pd, input bit ov, input int oq);
        bit   p_ok, o_ok;
        int   total;
        exp_t e;
        total = model_total();
        p_ok  = pv && (total < DEPTH);
        o_ok  = ov && (mq[oq].size() > 0);
        bus.push_valid = pv;
        bus.push_queue = 2'(pq);
        bus.push_data  = pd;
        bus.pop_valid  = ov;
        bus.pop_queue  = 2'(oq);
        #1;
        if (pv) check("push_ready", bus.push_ready, total < DEPTH);
        if (ov) check("pop_ready", bus.pop_ready, mq[oq].size() > 0);
        if (o_ok) begin
            e.data = mq[oq].pop_front();
            e.due  = cyc + 1;
            exp_q.push_back(e);
        end
        if (p_ok) mq[pq].push_back(pd);
        @(posedge clock);
        #1;
        bus.push_valid = 1'b0;
        bus.pop_valid  = 1'b0;
    endtask

    task automatic check_invariant();
        int s;
        s = int'(free_count);
        for (int i = 0; i < NQ; i++) begin
            s += occ_of(i);
            check($sformatf("occupancy[%0d]", i), occ_of(i), mq[i].size());
        end
        check("free+occupancy", s, DEPTH);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents pop data.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            cyc++;
            if (bus.pop_data_valid) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL pop_data_valid: got 1 expected 0 (no pop outstanding)");
                end else begin
                    e = exp_q.pop_front();
                    if (bus.pop_data !== e.data || e.due != cyc) begin
                        n_err++;
                        $display("FAIL pop_data: got %0h (cycle %0d) expected %0h (cycle %0d)",
                                 bus.pop_data, cyc, e.data, e.due);
                    end
                end
            end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
                n_vec++;
                n_err++;
                e = exp_q.pop_front();
                $display("FAIL pop_data_valid: got 0 expected 1 for data %0h", e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.push_valid = 1'b0;
        bus.push_queue = '0;
        bus.push_data  = '0;
        bus.pop_valid  = 1'b0;
        bus.pop_queue  = '0;
        thr            = '0;
`ifdef SHQ_WATERMARK_EN
        watermark_clear = 1'b0;
`endif
        reset = 1'b0;
        #23;
        reset = 1'b1;
        @(posedge clock);
        #1;

        // Reset state
        check("rst free_count", free_count, 16);
        check("rst push_ready", bus.push_ready, 1);
        check("rst empty", empty, 4'hF);
        check("rst last_elem", last_elem, 0);
        check("rst kill", kill, 0);
        check("rst pop_data_valid", bus.pop_data_valid, 0);
        check("rst occupancy", occupancy, 0);

        // 1: fill q2 with 0..15
        for (int i = 0; i < 16; i++) begin
            cycle(1, 2, data_t'(i), 0, 0);
            if (i == 14) check("push_ready before last", bus.push_ready, 1);
        end
        check("full push_ready", bus.push_ready, 0);
        check("full free_count", free_count, 0);
        check("full occupancy[2]", occ_of(2), 16);
        check("full empty", empty, 4'b1011);
        cycle(1, 0, data_t'(99), 0, 0);
        check("ignored push free_count", free_count, 0);
        check("ignored push occupancy[0]", occ_of(0), 0);

        // 2: drain q2 in order
        for (int i = 0; i < 16; i++) cycle(0, 0, '0, 1, 2);
        check("drain empty[2]", empty[2], 1);
        check("drain free_count", free_count, 16);
        cycle(0, 0, '0, 1, 2);
        check("ignored pop free_count", free_count, 16);

        // 3: interleaved queues
        cycle(1, 0, data_t'(32'hA), 0, 0);
        cycle(1, 1, data_t'(32'hB), 0, 0);
        cycle(1, 0, data_t'(32'hC), 0, 0);
        cycle(0, 0, '0, 1, 0);
        cycle(0, 0, '0, 1, 0);
        check("interleave occupancy[1]", occ_of(1), 1);
        check("interleave last_elem[1]", last_elem[1], 1);
        check("interleave empty[0]", empty[0], 1);

        // 4: simultaneous push+pop on a single-entry queue
        cycle(1, 3, data_t'(32'h5A5A), 0, 0);
        cycle(1, 3, data_t'(32'h7E7E), 1, 3);
        check("same-q occupancy[3]", occ_of(3), 1);
        check("same-q last_elem[3]", last_elem[3], 1);
        cycle(0, 0, '0, 1, 3);
        check("same-q drained occupancy[3]", occ_of(3), 0);

        // 5: kill threshold on q1
        cycle(0, 0, '0, 1, 1);
        thr[1*RS +: RS] = 32'd3;
        for (int i = 0; i < 4; i++) begin
            cycle(1, 1, data_t'(100 + i), 0, 0);
            check($sformatf("kill[1] after push %0d", i + 1), kill[1], (i == 3) ? 1 : 0);
        end
        cycle(0, 0, '0, 1, 1);
        check("kill[1] after pop", kill[1], 0);
        check("kill others", kill & 4'b1101, 0);

        // 6: one free slot, push q0 + pop q1 together
        for (int i = 0; i < 12; i++) cycle(1, 0, data_t'(200 + i), 0, 0);
        check("nearly full free_count", free_count, 1);
        cycle(1, 0, data_t'(300), 1, 1);
        check("swap free_count", free_count, 1);
        check("swap occupancy[0]", occ_of(0), 13);
        check("swap occupancy[1]", occ_of(1), 2);
        check("swap push_ready", bus.push_ready, 1);

        // Reset mid-stream with a pop result just presented
        cycle(0, 0, '0, 1, 0);
        #1;
        reset = 1'b0;
        #1;
        check("midrst pop_data_valid", bus.pop_data_valid, 0);
        check("midrst free_count", free_count, 16);
        check("midrst empty", empty, 4'hF);
        check("midrst occupancy", occupancy, 0);
        check("midrst kill", kill, 0);
        for (int i = 0; i < NQ; i++) mq[i].delete();
        exp_q.delete();
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;

        // Random traffic with invariant checks
        thr = '0;
        for (int n = 0; n < 300; n++) begin
            cycle(1'($urandom_range(0, 1)), $urandom_range(0, NQ - 1), data_t'({$urandom, $urandom}),
                  1'($urandom_range(0, 1)), $urandom_range(0, NQ - 1));
            check_invariant();
        end

        for (int q = 0; q < NQ; q++) begin
            for (int k = 0; k < DEPTH && mq[q].size() > 0; k++) cycle(0, 0, '0, 1, q);
        end
        cycle(0, 0, '0, 0, 0);
        cycle(0, 0, '0, 0, 0);
        check("final free_count", free_count, 16);
        check("scoreboard drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
